// File: rtl/regfile_io_injector_pkg.sv
// Shared constants and types for the register file input injector.
package regfile_io_injector_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PEND_W = 3;

  // Register file destinations owned by the injector
  localparam logic [REG_W-1:0] REG_Y    = 5'd1;
  localparam logic [REG_W-1:0] REG_X    = 5'd2;
  localparam logic [REG_W-1:0] REG_TRIG = 5'd5;

  // Pending flag bit positions (lower index wins arbitration)
  localparam int unsigned PEND_Y    = 0;
  localparam int unsigned PEND_X    = 1;
  localparam int unsigned PEND_TRIG = 2;

  // One register file write transaction
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } rf_write_t;

  // One position step: inc/dec only when exactly one is held, clamped to 0..max_v
  function automatic logic [DATA_W-1:0] step_pos(input logic [DATA_W-1:0] cur,
                                                 input logic              inc,
                                                 input logic              dec,
                                                 input logic [DATA_W-1:0] max_v);
    step_pos = cur;
    if (inc && !dec && (cur < max_v)) begin
      step_pos = cur + 32'd1;
    end else if (dec && !inc && (cur != 32'd0)) begin
      step_pos = cur - 32'd1;
    end
  endfunction

endpackage

// File: rtl/regfile_io_injector_button_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic btn_raw,
  output logic level
);

  logic        sync_a;
  logic        sync_b;
  logic [15:0] count;

  // Synchronise, then flip the level only after a full run at the new value
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      count  <= 16'd0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        count <= 16'd0;
      end else if (count >= (DEBOUNCE_CYCLES - 16'd1)) begin
        level <= sync_b;
        count <= 16'd0;
      end else begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/regfile_io_injector.sv
// Injects debounced button state and crosshair position into idle register
// file write cycles (r1 = Y, r2 = X, r5 = trigger). Processor writeback wins.
// Optional feature: define INJ_TRIGGER_EN to enable the trigger path to r5.
module regfile_io_injector
  import regfile_io_injector_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] STEP_CYCLES     = 24'd250000,
  parameter logic [31:0] Y_MAX           = 32'd479,
  parameter logic [31:0] X_MAX           = 32'd639
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              proc_writeEnable,
  input  logic [REG_W-1:0]  proc_writeReg,
  input  logic [DATA_W-1:0] proc_writeData,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_trigger,
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [PEND_W-1:0] inject_pending
);

  logic up_lvl, down_lvl, left_lvl, right_lvl;
  logic trig_rise;

  logic [23:0]       step_cnt;
  logic              step;
  logic [DATA_W-1:0] pos_y, pos_x;
  logic [DATA_W-1:0] pos_y_next, pos_x_next;
  logic [PEND_W-1:0] pending, pend_set, pend_consume;
  logic              proc_valid;
  rf_write_t         wr_c;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up    (.clock(clock), .ctrl_reset(ctrl_reset), .btn_raw(btn_up),    .level(up_lvl));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down  (.clock(clock), .ctrl_reset(ctrl_reset), .btn_raw(btn_down),  .level(down_lvl));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left  (.clock(clock), .ctrl_reset(ctrl_reset), .btn_raw(btn_left),  .level(left_lvl));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (.clock(clock), .ctrl_reset(ctrl_reset), .btn_raw(btn_right), .level(right_lvl));

`ifdef INJ_TRIGGER_EN
  logic trig_lvl;
  logic trig_prev;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig (.clock(clock), .ctrl_reset(ctrl_reset), .btn_raw(btn_trigger), .level(trig_lvl));

  // Previous debounced trigger level for rising-edge detection
  always_ff @(posedge clock) begin
    if (ctrl_reset) trig_prev <= 1'b0;
    else            trig_prev <= trig_lvl;
  end

  assign trig_rise = trig_lvl & ~trig_prev;
`else
  logic unused_trigger;
  assign unused_trigger = btn_trigger;
  assign trig_rise      = 1'b0;
`endif

  assign step       = (step_cnt == (STEP_CYCLES - 24'd1));
  assign proc_valid = proc_writeEnable && (proc_writeReg != 5'd0);

  // Next positions and pending-set events; a clamp that changes nothing sets nothing
  always_comb begin
    pos_y_next = pos_y;
    pos_x_next = pos_x;
    pend_set   = '0;
    if (step) begin
      pos_y_next = step_pos(pos_y, down_lvl, up_lvl, Y_MAX);
      pos_x_next = step_pos(pos_x, right_lvl, left_lvl, X_MAX);
    end
    pend_set[PEND_Y]    = (pos_y_next != pos_y);
    pend_set[PEND_X]    = (pos_x_next != pos_x);
    pend_set[PEND_TRIG] = trig_rise;
  end

  // Write port arbitration: valid processor write, then lowest pending bit, then r0 passthrough
  always_comb begin
    wr_c         = '0;
    pend_consume = '0;
    if (proc_valid) begin
      wr_c = '{we: 1'b1, addr: proc_writeReg, data: proc_writeData};
    end else if (pending[PEND_Y]) begin
      wr_c                 = '{we: 1'b1, addr: REG_Y, data: pos_y};
      pend_consume[PEND_Y] = 1'b1;
    end else if (pending[PEND_X]) begin
      wr_c                 = '{we: 1'b1, addr: REG_X, data: pos_x};
      pend_consume[PEND_X] = 1'b1;
    end else if (pending[PEND_TRIG]) begin
      wr_c                    = '{we: 1'b1, addr: REG_TRIG, data: 32'd1};
      pend_consume[PEND_TRIG] = 1'b1;
    end else if (proc_writeEnable) begin
      wr_c = '{we: 1'b1, addr: proc_writeReg, data: proc_writeData};
    end
  end

  // Step timer, positions and pending flags; a new event beats a same-cycle consume
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      step_cnt <= 24'd0;
      pos_y    <= Y_MAX >> 1;
      pos_x    <= X_MAX >> 1;
      pending  <= '0;
    end else begin
      step_cnt <= step ? 24'd0 : (step_cnt + 24'd1);
      pos_y    <= pos_y_next;
      pos_x    <= pos_x_next;
      pending  <= (pending & ~pend_consume) | pend_set;
    end
  end

  assign ctrl_writeEnable = wr_c.we;
  assign ctrl_writeReg    = wr_c.addr;
  assign data_writeReg    = wr_c.data;
  assign inject_pending   = pending;

endmodule

// File: tb/tb_regfile_io_injector.sv
// Directed bench for regfile_io_injector (DEBOUNCE_CYCLES=4, STEP_CYCLES=8).
module tb_regfile_io_injector;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        proc_writeEnable;
  logic [4:0]  proc_writeReg;
  logic [31:0] proc_writeData;
  logic        btn_up, btn_down, btn_left, btn_right, btn_trigger;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [2:0]  inject_pending;

  int errors = 0;
  int checks = 0;
  int n_r1 = 0, n_r2 = 0, n_r5 = 0;

  logic [31:0] d;
  int          w;
  int          base;
  bit          hit;

  always #5 clock = ~clock;

  regfile_io_injector #(
    .DEBOUNCE_CYCLES(16'd4),
    .STEP_CYCLES    (24'd8),
    .Y_MAX          (32'd479),
    .X_MAX          (32'd639)
  ) dut (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .proc_writeEnable(proc_writeEnable),
    .proc_writeReg   (proc_writeReg),
    .proc_writeData  (proc_writeData),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_trigger     (btn_trigger),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .inject_pending  (inject_pending)
  );

  // Count register file writes per destination, sampled mid-cycle
  always @(negedge clock) begin
    if (ctrl_writeEnable === 1'b1) begin
      if (ctrl_writeReg == 5'd1) n_r1 <= n_r1 + 1;
      if (ctrl_writeReg == 5'd2) n_r2 <= n_r2 + 1;
      if (ctrl_writeReg == 5'd5) n_r5 <= n_r5 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic proc(input logic we, input logic [4:0] r, input logic [31:0] dat);
    proc_writeEnable = we;
    proc_writeReg    = r;
    proc_writeData   = dat;
  endtask

  // Wait up to budget negedges for a write to register r; n = negedges consumed
  task automatic wait_wr(input logic [4:0] r, input int budget, input string tag,
                         output logic [31:0] dat, output int n);
    bit found = 1'b0;
    dat = 32'd0;
    n   = 0;
    while (!found && n < budget) begin
      @(negedge clock);
      n++;
      if (ctrl_writeEnable === 1'b1 && ctrl_writeReg === r) begin
        found = 1'b1;
        dat   = data_writeReg;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    ctrl_reset = 1'b1;
    proc(1'b0, 5'd0, 32'd0);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_trigger = 0;

    // Reset and idle behaviour
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_we",   32'(ctrl_writeEnable), 32'd0);
    chk("rst_pend", 32'(inject_pending),   32'd0);
    @(posedge clock); #2 ctrl_reset = 1'b0;
    @(negedge clock);
    chk("idle_we",   32'(ctrl_writeEnable), 32'd0);
    chk("idle_reg",  32'(ctrl_writeReg),    32'd0);
    chk("idle_data", data_writeReg,         32'd0);

    @(posedge clock); #2 proc(1'b1, 5'd7, 32'h1234_5678);
    @(negedge clock);
    chk("pass_we",   32'(ctrl_writeEnable), 32'd1);
    chk("pass_reg",  32'(ctrl_writeReg),    32'd7);
    chk("pass_data", data_writeReg,         32'h1234_5678);
    @(posedge clock); #2 proc(1'b1, 5'd0, 32'hDEAD_BEEF);
    @(negedge clock);
    chk("r0_we",   32'(ctrl_writeEnable), 32'd1);
    chk("r0_reg",  32'(ctrl_writeReg),    32'd0);
    chk("r0_data", data_writeReg,         32'hDEAD_BEEF);
    @(posedge clock); #2 proc(1'b0, 5'd7, 32'h0000_FFFF);
    @(negedge clock);
    chk("noen_we",   32'(ctrl_writeEnable), 32'd0);
    chk("noen_data", data_writeReg,         32'd0);
    @(posedge clock); #2 proc(1'b0, 5'd0, 32'd0);

    // Hold down: 240 first, then +1 every 8 cycles, saturating at 479
    btn_down = 1'b1;
    wait_wr(5'd1, 40, "down_first", d, w);
    chk("down_first_data", d, 32'd240);
    for (int v = 241; v <= 479; v++) begin
      wait_wr(5'd1, 12, "down_step", d, w);
      chk("down_data",     d,       32'(v));
      chk("down_interval", 32'(w),  32'd8);
    end
    @(posedge clock); base = n_r1;
    repeat (40) @(negedge clock);
    @(posedge clock);
    chk("sat_writes", 32'(n_r1 - base),          32'd0);
    chk("sat_pend",   32'(inject_pending[0]),    32'd0);
    btn_down = 1'b0;
    repeat (20) @(posedge clock);

    // Bounce on left: never settles, so no pending and no r2 write
    base = n_r2;
    hit  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_left = ~btn_left;
      repeat (2) begin
        @(negedge clock);
        if (inject_pending != 3'd0) hit = 1'b1;
      end
    end
    repeat (10) begin
      @(negedge clock);
      if (inject_pending != 3'd0) hit = 1'b1;
    end
    @(posedge clock);
    chk("bounce_writes", 32'(n_r2 - base), 32'd0);
    chk("bounce_pend",   32'(hit),         32'd0);

    // Contention: processor r7 for 3 cycles holds off the Y injection
    #2 btn_up = 1'b1;
    wait_wr(5'd1, 40, "up_first", d, w);
    chk("up_first_data", d, 32'd478);
    repeat (8) @(posedge clock);
    #2 proc(1'b1, 5'd7, 32'hA5A5_0007);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("cont_reg",  32'(ctrl_writeReg),     32'd7);
      chk("cont_data", data_writeReg,          32'hA5A5_0007);
      chk("cont_pend", 32'(inject_pending[0]), 32'd1);
      @(posedge clock);
    end
    #2 proc(1'b0, 5'd0, 32'd0);
    @(negedge clock);
    chk("cont_inj_reg",  32'(ctrl_writeReg), 32'd1);
    chk("cont_inj_data", data_writeReg,      32'd477);
    repeat (5) @(posedge clock);
    #2 proc(1'b1, 5'd0, 32'hDEAD_0000);
    @(negedge clock);
    chk("r0_inj_we",   32'(ctrl_writeEnable), 32'd1);
    chk("r0_inj_reg",  32'(ctrl_writeReg),    32'd1);
    chk("r0_inj_data", data_writeReg,         32'd476);
    btn_up = 1'b0;
    @(posedge clock); #2 proc(1'b0, 5'd0, 32'd0);
    @(negedge clock);
    chk("r0_inj_clear", 32'(inject_pending[0]), 32'd0);

    // Y and X pending together: r1 then r2 on consecutive idle cycles
    repeat (20) @(posedge clock);
    #2 btn_down = 1'b1; btn_right = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      if (inject_pending[1:0] == 2'b11) hit = 1'b1;
    end
    chk("yx_seen",      32'(hit),           32'd1);
    chk("yx_first_reg", 32'(ctrl_writeReg), 32'd1);
    chk("yx_first_dat", data_writeReg,      32'd477);
    btn_down = 1'b0; btn_right = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("yx_second_reg", 32'(ctrl_writeReg),  32'd2);
    chk("yx_second_dat", data_writeReg,       32'd320);
    chk("yx_second_pnd", 32'(inject_pending), 32'd2);
    @(posedge clock); @(negedge clock);
    chk("yx_done_we", 32'(ctrl_writeEnable), 32'd0);

    // X change in the same cycle X is consumed: second r2 write carries newest value
    repeat (20) @(posedge clock);
    #2 btn_left = 1'b1;
    wait_wr(5'd2, 40, "left_first", d, w);
    chk("left_first_data", d, 32'd319);
    repeat (7) @(posedge clock);
    #2 proc(1'b1, 5'd7, 32'h0000_0077);
    repeat (8) @(posedge clock);
    #2 proc(1'b0, 5'd0, 32'd0);
    @(negedge clock);
    chk("stale_old_reg", 32'(ctrl_writeReg), 32'd2);
    chk("stale_old_dat", data_writeReg,      32'd318);
    @(posedge clock); @(negedge clock);
    chk("stale_new_reg", 32'(ctrl_writeReg), 32'd2);
    chk("stale_new_dat", data_writeReg,      32'd317);
    btn_left = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("stale_clear", 32'(inject_pending), 32'd0);

    // Trigger: one r5 := 1 per press when enabled, never otherwise
    repeat (10) @(posedge clock);
    base = n_r5;
`ifdef INJ_TRIGGER_EN
    btn_trigger = 1'b1;
    wait_wr(5'd5, 40, "trig", d, w);
    chk("trig_data", d, 32'd1);
    repeat (40) @(negedge clock);
    btn_trigger = 1'b0;
    repeat (10) @(negedge clock);
    @(posedge clock);
    chk("trig_count", 32'(n_r5 - base), 32'd1);
`else
    btn_trigger = 1'b1;
    hit = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (inject_pending[2] !== 1'b0) hit = 1'b1;
    end
    btn_trigger = 1'b0;
    @(posedge clock);
    chk("trig_off_count", 32'(n_r5 - base), 32'd0);
    chk("trig_off_pend",  32'(hit),         32'd0);
`endif

    // Reset mid-operation drops a held-off injection and restores positions
    #2 proc(1'b1, 5'd7, 32'h0000_0007);
    btn_right = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      if (inject_pending[1] === 1'b1) hit = 1'b1;
    end
    chk("rst_mid_seen", 32'(hit), 32'd1);
    btn_right = 1'b0;
    @(posedge clock); #2 ctrl_reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("rst_mid_pend", 32'(inject_pending), 32'd0);
    @(posedge clock); #2 ctrl_reset = 1'b0; proc(1'b0, 5'd0, 32'd0);
    @(posedge clock); base = n_r2;
    repeat (30) @(negedge clock);
    @(posedge clock);
    chk("rst_mid_writes", 32'(n_r2 - base), 32'd0);

    #2 btn_up = 1'b1; btn_left = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      if (inject_pending[1:0] == 2'b11) hit = 1'b1;
    end
    chk("rst_pos_seen", 32'(hit),           32'd1);
    chk("rst_pos_yreg", 32'(ctrl_writeReg), 32'd1);
    chk("rst_pos_ydat", data_writeReg,      32'd238);
    btn_up = 1'b0; btn_left = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("rst_pos_xreg", 32'(ctrl_writeReg), 32'd2);
    chk("rst_pos_xdat", data_writeReg,      32'd318);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
